serial_kbd_receiver: RTL and testbench

UART 8N1 receiver with a small byte FIFO and an interrupt-driven word bus. It sits between the board's serial RX pin and the system controller FSM, and turns host keystrokes into 16-bit words. The controller reaches it through the same enable/write/addr/data plus irq/iack/iend protocol the graphics side uses.

---
 rtl/serial_kbd_receiver.sv | 149 ++++++++++++++
 tb/tb_serial_kbd_receiver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_kbd_receiver.sv
// serial_kbd_receiver: UART 8N1 receiver with byte FIFO and IRQ-driven word bus
module serial_kbd_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic        WRITE,
  input  logic [15:0] ADDR,
  output logic [15:0] DATA_R,
  input  logic [15:0] DATA_W,
  output logic        IRQ,
  input  logic        IACK,
  input  logic        IEND,
  input  logic        IN_SERIAL_RX
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  // START samples two cycles early because IDLE spends one cycle detecting the edge
  localparam logic [CW-1:0] HALF_M2 = CW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic {S_IDLE, S_SERVICE} svc_state_t;

  rx_state_t  rx_state, rx_next;
  svc_state_t svc, svc_next;
  logic          rx_meta, rx_sync;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          push_try, ferr_set;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [4:0]    count;
  logic          ovr, ferr;
  logic          rd, pop, push, full, clr;
  logic          unused_bits;

  assign unused_bits = ^{ADDR[15:1], DATA_W[15:1]};
  assign rd   = ENABLE & ~WRITE;
  assign pop  = rd & ~ADDR[0] & (count != 5'd0);
  assign full = count == 5'(FIFO_DEPTH);
  assign push = push_try & (~full | pop);
  assign clr  = ENABLE & WRITE & ADDR[0] & DATA_W[0];

  // two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) {rx_meta, rx_sync} <= 2'b11;
    else {rx_meta, rx_sync} <= {IN_SERIAL_RX, rx_meta};

  // receive FSM state, bit timer, bit index and shift register
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      rx_state <= rx_next;
      cnt      <= cnt_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
    end

  // receive FSM next state: mid-bit sampling of start, eight data bits LSB first, stop
  always_comb begin
    rx_next    = rx_state;
    cnt_next   = cnt + 1'b1;
    bit_next   = bit_idx;
    shift_next = shift;
    push_try   = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        cnt_next = '0;
        bit_next = '0;
        rx_next  = rx_sync ? RX_IDLE : RX_START;
      end
      RX_START:
        if (cnt == HALF_M2) begin
          cnt_next = '0;
          rx_next  = rx_sync ? RX_IDLE : RX_DATA;
        end
      RX_DATA:
        if (cnt == FULL_M1) begin
          cnt_next   = '0;
          shift_next = {rx_sync, shift[7:1]};
          bit_next   = bit_idx + 1'b1;
          rx_next    = (bit_idx == 3'd7) ? RX_STOP : RX_DATA;
        end
      RX_STOP:
        if (cnt == FULL_M1) begin
          cnt_next = '0;
          push_try = rx_sync;
          ferr_set = ~rx_sync;
          rx_next  = rx_sync ? RX_IDLE : RX_WAIT;
        end
      RX_WAIT: begin
        cnt_next = '0;
        rx_next  = rx_sync ? RX_IDLE : RX_WAIT;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // FIFO storage; occupancy lives in the pointers, so no reset is needed here
  always_ff @(posedge CLK)
    if (push) mem[wp] <= shift;

  // FIFO pointers, occupancy and sticky error flags (a new error wins over a clear)
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovr   <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      wp    <= push ? wp + 1'b1 : wp;
      rp    <= pop ? rp + 1'b1 : rp;
      count <= count + 5'(push) - 5'(pop);
      ovr   <= (push_try & full & ~pop) | (ovr & ~clr);
      ferr  <= ferr_set | (ferr & ~clr);
    end

  // registered read data, held between reads
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) DATA_R <= '0;
    else if (rd) DATA_R <= ADDR[0] ? {ovr, ferr, 9'b0, count} : {8'h00, (count != 5'd0) ? mem[rp] : 8'h00};

  // service FSM next state; stray IACK in service and IEND in idle fall through
  always_comb begin
    svc_next = svc;
    if (svc == S_IDLE && IACK) svc_next = S_SERVICE;
    if (svc == S_SERVICE && IEND) svc_next = S_IDLE;
  end

  // service state and IRQ; IRQ uses the current state so it stays low a cycle after IEND
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      svc <= S_IDLE;
      IRQ <= 1'b0;
    end else begin
      svc <= svc_next;
      IRQ <= (svc == S_IDLE) & ~IACK & (count != 5'd0);
    end
endmodule

// File: tb/tb_serial_kbd_receiver.sv
// tb_serial_kbd_receiver: directed and randomized checks against a queue-based model
module tb_serial_kbd_receiver;
  localparam int C = 16;
  localparam int D = 8;
  localparam int H = C / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        write = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_w = '0;
  logic [15:0] data_r;
  logic        irq;
  logic        iack = 1'b0;
  logic        iend = 1'b0;
  logic        rx = 1'b1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  bit         ovr_m = 1'b0;
  bit         ferr_m = 1'b0;
  bit         svc_m = 1'b0;

  serial_kbd_receiver #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .CLK(clk), .RESET_N(rst_n), .ENABLE(enable), .WRITE(write), .ADDR(addr),
    .DATA_R(data_r), .DATA_W(data_w), .IRQ(irq), .IACK(iack), .IEND(iend),
    .IN_SERIAL_RX(rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(C);
    end
    rx = stop;
    tick(C);
    if (!stop) ferr_m = 1'b1;
    else if (q.size() < D) q.push_back(b);
    else ovr_m = 1'b1;
  endtask

  task automatic bus_read(input bit a, output logic [15:0] d);
    enable = 1'b1;
    write = 1'b0;
    addr = {15'b0, a};
    tick(1);
    enable = 1'b0;
    d = data_r;
  endtask

  task automatic rd_data(input string tag);
    logic [15:0] d, e;
    e = 16'h0000;
    if (q.size() != 0) e = {8'h00, q.pop_front()};
    bus_read(1'b0, d);
    check(tag, d, e);
  endtask

  task automatic rd_status(input string tag);
    logic [15:0] d;
    bus_read(1'b1, d);
    check(tag, d, {ovr_m, ferr_m, 9'b0, 5'(q.size())});
  endtask

  task automatic clr_flags();
    enable = 1'b1;
    write = 1'b1;
    addr = 16'h0001;
    data_w = 16'h0001;
    tick(1);
    enable = 1'b0;
    write = 1'b0;
    ovr_m = 1'b0;
    ferr_m = 1'b0;
  endtask

  task automatic pulse_iack();
    iack = 1'b1;
    tick(1);
    iack = 1'b0;
    svc_m = 1'b1;
  endtask

  task automatic pulse_iend();
    iend = 1'b1;
    tick(1);
    iend = 1'b0;
    svc_m = 1'b0;
  endtask

  task automatic chk_irq(input string tag);
    tick(2);
    check(tag, {15'b0, irq}, {15'b0, !svc_m && q.size() != 0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    bit         stop;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_data_r", data_r, 16'h0000);
    check("rst_irq", {15'b0, irq}, 16'h0000);
    rd_status("rst_status");

    fork
      send_byte(8'h31, 1'b1);
      begin
        repeat (H + 9 * C + 2) @(posedge clk);
        @(negedge clk);
        check("irq_before_push", {15'b0, irq}, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        check("irq_rise", {15'b0, irq}, 16'h0001);
      end
    join
    pulse_iack();
    check("irq_fall_iack", {15'b0, irq}, 16'h0000);
    pulse_iack();
    rd_data("t1_read");
    pulse_iend();
    chk_irq("t1_irq_after_iend");
    rd_status("t1_status");

    send_byte(8'h32, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h34, 1'b1);
    rd_status("t2_count3");
    pulse_iack();
    pulse_iend();
    @(negedge clk);
    check("irq_gap", {15'b0, irq}, 16'h0000);
    tick(1);
    check("irq_reassert", {15'b0, irq}, 16'h0001);
    for (int i = 0; i < 4; i++) rd_data("t2_read");
    rd_status("t2_empty");
    chk_irq("t2_irq");

    for (int i = 0; i <= D; i++) send_byte(8'h40 + 8'(i), 1'b1);
    rd_status("t3_overflow");
    for (int i = 0; i < D; i++) rd_data("t3_read");
    clr_flags();
    rd_status("t3_cleared");

    send_byte(8'h55, 1'b0);
    tick(3 * C);
    chk_irq("t4_irq");
    rd_status("t4_ferr");
    rx = 1'b1;
    tick(C);
    send_byte(8'h31, 1'b1);
    rd_data("t4_read");
    clr_flags();
    rd_status("t4_cleared");

    rx = 1'b0;
    tick(C / 4);
    rx = 1'b1;
    tick(2 * C);
    chk_irq("t5_irq");
    rd_status("t5_status");
    send_byte(8'hA7, 1'b1);
    rd_data("t5_read");

    send_byte(8'h37, 1'b1);
    chk_irq("t6_irq_pending");
    b = 8'h35;
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(C);
    end
    rx = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t6_irq_async", {15'b0, irq}, 16'h0000);
    q.delete();
    ovr_m = 1'b0;
    ferr_m = 1'b0;
    svc_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_irq_in_reset", {15'b0, irq}, 16'h0000);
    end
    tick(1);
    rst_n = 1'b1;
    tick(2);
    send_byte(8'h36, 1'b1);
    rd_data("t6_read36");
    rd_data("t6_read_empty");
    rd_status("t6_status");

    for (int it = 0; it < 25; it++) begin
      int n;
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        stop = $urandom_range(0, 7) != 0;
        send_byte(b, stop);
        if (!stop) begin
          rx = 1'b1;
          tick(C);
        end
        tick($urandom_range(0, 5));
      end
      if ($urandom_range(0, 4) == 0) begin
        rx = 1'b0;
        tick($urandom_range(1, C / 4));
        rx = 1'b1;
        tick(C);
      end
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) rd_data("rnd_read");
      case ($urandom_range(0, 4))
        0: rd_status("rnd_status");
        1: clr_flags();
        2: pulse_iack();
        3: pulse_iend();
        default: tick(1);
      endcase
      chk_irq("rnd_irq");
    end
    rd_status("rnd_final_status");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
